load_store_unit: RTL and testbench

- Memory-side end of the load/store control path. Consumes the per-instruction mem_read_type / mem_write_mask codes produced by instruction decode and executes one data-memory transaction on a req/ack bus.
- Handles byte-lane steering, store data replication, load extraction with sign/zero extension, alignment checking, and a done/err handshake back to the core.
- Sits between the ALU address output and the data memory.

---
 rtl/load_store_unit.sv | 196 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Executes one data-memory load or store per start strobe over a req/ack bus.
// Handles lane steering, load extension, alignment checks, and the optional LSU_TIMEOUT_EN abort.
//   state | meaning
//   IDLE  | waiting for start
//   REQ   | bus_req high, waiting for bus_ack
//   DONE  | one-cycle done pulse
//   ERR   | one-cycle err pulse (illegal, misaligned, timeout)
module load_store_unit #(
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [2:0]        mem_read_type,
   input  logic [3:0]        mem_write_mask,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [31:0]       rdata,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [3:0]        bus_be,
   output logic [31:0]       bus_wdata,
   input  logic              bus_ack,
   input  logic [31:0]       bus_rdata
);

   localparam logic [2:0] RD_NONE = 3'd0;
   localparam logic [2:0] RD_BYTE = 3'd1;
   localparam logic [2:0] RD_HALF = 3'd2;
   localparam logic [2:0] RD_WORD = 3'd3;
   localparam logic [2:0] RD_B_U  = 3'd4;
   localparam logic [2:0] RD_H_U  = 3'd5;

   localparam logic [3:0] WR_NONE = 4'b0000;
   localparam logic [3:0] WR_BYTE = 4'b0001;
   localparam logic [3:0] WR_HALF = 4'b0011;
   localparam logic [3:0] WR_WORD = 4'b1111;

   typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

   state_t            state_q, state_d;
   logic [1:0]        off_q, off_d;
   logic [2:0]        rt_q, rt_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
   logic [3:0]        be_q, be_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [31:0]       load_val;
   logic              timeout;

   logic rd_none, wr_none, rd_legal, wr_legal, is_half, is_word, misaligned;

   always_comb begin
      rd_none    = (mem_read_type == RD_NONE);
      wr_none    = (mem_write_mask == WR_NONE);
      rd_legal   = (mem_read_type <= RD_H_U);
      wr_legal   = wr_none || (mem_write_mask == WR_BYTE) ||
                   (mem_write_mask == WR_HALF) || (mem_write_mask == WR_WORD);
      is_half    = (mem_read_type == RD_HALF) || (mem_read_type == RD_H_U) ||
                   (mem_write_mask == WR_HALF);
      is_word    = (mem_read_type == RD_WORD) || (mem_write_mask == WR_WORD);
      misaligned = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
   end

`ifdef LSU_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) < 8) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Counter sits at zero outside REQ, so it is clear on every REQ entry.
   always_comb begin
      cnt_d = '0;
      if (state_q == REQ && !bus_ack)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign timeout = (state_q == REQ) && !bus_ack &&
                    (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         off_q      <= '0;
         rt_q       <= RD_NONE;
         we_q       <= 1'b0;
         bus_addr_q <= '0;
         be_q       <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         off_q      <= off_d;
         rt_q       <= rt_d;
         we_q       <= we_d;
         bus_addr_q <= bus_addr_d;
         be_q       <= be_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (rd_none && wr_none)
                  state_d = DONE;
               else if ((!rd_none && !wr_none) || !rd_legal || !wr_legal || misaligned)
                  state_d = ERR;
               else
                  state_d = REQ;
            end
         end
         REQ: begin
            if (bus_ack)      state_d = DONE;
            else if (timeout) state_d = ERR;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy    = (state_q == REQ);
      bus_req = (state_q == REQ);
      done    = (state_q == DONE);
      err     = (state_q == ERR);
   end

   always_comb begin
      load_val = bus_rdata;
      case (rt_q)
         RD_BYTE, RD_B_U: begin
            load_val = {24'h0, bus_rdata[8*off_q +: 8]};
            if (rt_q == RD_BYTE && bus_rdata[8*off_q + 7])
               load_val[31:8] = 24'hFF_FFFF;
         end
         RD_HALF, RD_H_U: begin
            load_val = off_q[1] ? {16'h0, bus_rdata[31:16]} : {16'h0, bus_rdata[15:0]};
            if (rt_q == RD_HALF && load_val[15])
               load_val[31:16] = 16'hFFFF;
         end
         default: load_val = bus_rdata;
      endcase
   end

   // Bus fields are only captured when a real access is launched, so they hold through REQ.
   always_comb begin
      off_d      = off_q;
      rt_d       = rt_q;
      we_d       = we_q;
      bus_addr_d = bus_addr_q;
      be_d       = be_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      if (state_q == IDLE && state_d == REQ) begin
         off_d      = addr[1:0];
         rt_d       = mem_read_type;
         we_d       = !wr_none;
         bus_addr_d = {addr[ADDR_W-1:2], 2'b00};
         if (wr_none) begin
            be_d    = 4'b1111;
            wdata_d = '0;
         end else begin
            be_d = mem_write_mask << addr[1:0];
            case (mem_write_mask)
               WR_BYTE: wdata_d = {4{wdata[7:0]}};
               WR_HALF: wdata_d = {2{wdata[15:0]}};
               default: wdata_d = wdata;
            endcase
         end
      end
      if (state_q == REQ && bus_ack && !we_q)
         rdata_d = load_val;
   end

   assign rdata     = rdata_q;
   assign bus_we    = we_q;
   assign bus_addr  = bus_addr_q;
   assign bus_be    = be_q;
   assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table of single transactions plus
// hand-written sequences for start-while-busy, reset mid-REQ and timeout.
module tb_load_store_unit;

   localparam logic [2:0] RD_NONE = 3'd0, RD_BYTE = 3'd1, RD_HALF = 3'd2,
                          RD_WORD = 3'd3, RD_B_U = 3'd4, RD_H_U = 3'd5;
   localparam logic [3:0] WR_NONE = 4'b0000, WR_BYTE = 4'b0001,
                          WR_HALF = 4'b0011, WR_WORD = 4'b1111;
   localparam int K_BUS = 0, K_DONE = 1, K_ERR = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  mem_read_type = '0;
   logic [3:0]  mem_write_mask = '0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic        busy, done, err, bus_req, bus_we;
   logic [31:0] rdata, bus_addr, bus_wdata;
   logic [3:0]  bus_be;
   logic        bus_ack = 1'b0;
   logic [31:0] bus_rdata = '0;

   int n_tests = 0;
   int n_fail  = 0;

   load_store_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .start(start),
      .mem_read_type(mem_read_type), .mem_write_mask(mem_write_mask),
      .addr(addr), .wdata(wdata),
      .busy(busy), .done(done), .err(err), .rdata(rdata),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_be(bus_be), .bus_wdata(bus_wdata),
      .bus_ack(bus_ack), .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  rt;
      logic [3:0]  wm;
      logic [31:0] a;
      logic [31:0] wd;
      int          waits;
      logic [31:0] brd;
      int          kind;
      logic        exp_we;
      logic [31:0] exp_addr;
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic start_txn(input logic [2:0] rt, input logic [3:0] wm,
                            input logic [31:0] a, input logic [31:0] wd);
      @(negedge clk);
      start = 1'b1; mem_read_type = rt; mem_write_mask = wm; addr = a; wdata = wd;
      @(negedge clk);
      start = 1'b0; mem_read_type = RD_NONE; mem_write_mask = WR_NONE;
   endtask

   initial begin
      //         rt       wm       addr          wdata         w  bus_rdata     kind    we    bus_addr      be       bus_wdata     rdata
      vecs[0]  = '{RD_BYTE, WR_NONE, 32'h0000_1003, 32'h0,         2, 32'h80FF_1234, K_BUS,  1'b0, 32'h0000_1000, 4'b1111, 32'h0,         32'hFFFF_FF80};
      vecs[1]  = '{RD_NONE, WR_HALF, 32'h0000_2002, 32'hDEAD_BEEF, 0, 32'h5555_5555, K_BUS,  1'b1, 32'h0000_2000, 4'b1100, 32'hBEEF_BEEF, 32'hFFFF_FF80};
      vecs[2]  = '{RD_WORD, WR_NONE, 32'h0000_3001, 32'h0,         0, 32'h0,         K_ERR,  1'b0, 32'h0,         4'b0000, 32'h0,         32'hFFFF_FF80};
      vecs[3]  = '{RD_NONE, WR_HALF, 32'h0000_3003, 32'h1234_5678, 0, 32'h0,         K_ERR,  1'b0, 32'h0,         4'b0000, 32'h0,         32'hFFFF_FF80};
      vecs[4]  = '{RD_H_U,  WR_NONE, 32'h0000_4002, 32'h0,         1, 32'h9ABC_0000, K_BUS,  1'b0, 32'h0000_4000, 4'b1111, 32'h0,         32'h0000_9ABC};
      vecs[5]  = '{RD_B_U,  WR_NONE, 32'h0000_4001, 32'h0,         0, 32'h0000_F100, K_BUS,  1'b0, 32'h0000_4000, 4'b1111, 32'h0,         32'h0000_00F1};
      vecs[6]  = '{RD_HALF, WR_NONE, 32'h0000_4000, 32'h0,         0, 32'h0000_8001, K_BUS,  1'b0, 32'h0000_4000, 4'b1111, 32'h0,         32'hFFFF_8001};
      vecs[7]  = '{RD_WORD, WR_NONE, 32'h0000_5000, 32'h0,         0, 32'h1234_5678, K_BUS,  1'b0, 32'h0000_5000, 4'b1111, 32'h0,         32'h1234_5678};
      vecs[8]  = '{RD_NONE, WR_BYTE, 32'h0000_6001, 32'h0000_00A5, 1, 32'hFFFF_FFFF, K_BUS,  1'b1, 32'h0000_6000, 4'b0010, 32'hA5A5_A5A5, 32'h1234_5678};
      vecs[9]  = '{RD_NONE, WR_WORD, 32'h0000_6004, 32'hCAFE_F00D, 0, 32'h0,         K_BUS,  1'b1, 32'h0000_6004, 4'b1111, 32'hCAFE_F00D, 32'h1234_5678};
      vecs[10] = '{RD_NONE, WR_NONE, 32'h0000_7000, 32'h0,         0, 32'h0,         K_DONE, 1'b0, 32'h0,         4'b0000, 32'h0,         32'h1234_5678};
      vecs[11] = '{RD_WORD, WR_WORD, 32'h0000_7000, 32'h0,         0, 32'h0,         K_ERR,  1'b0, 32'h0,         4'b0000, 32'h0,         32'h1234_5678};
      vecs[12] = '{3'd7,    WR_NONE, 32'h0000_7000, 32'h0,         0, 32'h0,         K_ERR,  1'b0, 32'h0,         4'b0000, 32'h0,         32'h1234_5678};

      repeat (3) @(negedge clk);
      check("reset_busy", {31'h0, busy}, 32'h0);
      check("reset_done", {31'h0, done}, 32'h0);
      check("reset_err", {31'h0, err}, 32'h0);
      check("reset_req", {31'h0, bus_req}, 32'h0);
      check("reset_rdata", rdata, 32'h0);
      check("reset_be", {28'h0, bus_be}, 32'h0);
      rst = 1'b0;

      for (int i = 0; i < 13; i++) begin
         start_txn(vecs[i].rt, vecs[i].wm, vecs[i].a, vecs[i].wd);
         if (vecs[i].kind == K_BUS) begin
            check($sformatf("v%0d_req", i), {31'h0, bus_req}, 32'h1);
            check($sformatf("v%0d_busy", i), {31'h0, busy}, 32'h1);
            check($sformatf("v%0d_we", i), {31'h0, bus_we}, {31'h0, vecs[i].exp_we});
            check($sformatf("v%0d_addr", i), bus_addr, vecs[i].exp_addr);
            check($sformatf("v%0d_be", i), {28'h0, bus_be}, {28'h0, vecs[i].exp_be});
            if (vecs[i].exp_we)
               check($sformatf("v%0d_wdata", i), bus_wdata, vecs[i].exp_wdata);
            for (int w = 0; w < vecs[i].waits; w++) begin
               check($sformatf("v%0d_nodone_wait", i), {31'h0, done}, 32'h0);
               @(negedge clk);
               check($sformatf("v%0d_req_wait", i), {31'h0, bus_req}, 32'h1);
            end
            check($sformatf("v%0d_addr_hold", i), bus_addr, vecs[i].exp_addr);
            bus_ack = 1'b1; bus_rdata = vecs[i].brd;
            @(negedge clk);
            bus_ack = 1'b0;
            check($sformatf("v%0d_done", i), {31'h0, done}, 32'h1);
            check($sformatf("v%0d_req_drop", i), {31'h0, bus_req}, 32'h0);
         end else begin
            check($sformatf("v%0d_done", i), {31'h0, done}, {31'h0, vecs[i].kind == K_DONE});
            check($sformatf("v%0d_err", i), {31'h0, err}, {31'h0, vecs[i].kind == K_ERR});
            check($sformatf("v%0d_noreq", i), {31'h0, bus_req}, 32'h0);
         end
         check($sformatf("v%0d_busy_end", i), {31'h0, busy}, 32'h0);
         check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
         @(negedge clk);
         check($sformatf("v%0d_pulse_done", i), {31'h0, done}, 32'h0);
         check($sformatf("v%0d_pulse_err", i), {31'h0, err}, 32'h0);
      end

      // start pulsed during REQ must not launch a second transaction
      start_txn(RD_WORD, WR_NONE, 32'h0000_7000, 32'h0);
      start = 1'b1; mem_read_type = RD_NONE; mem_write_mask = WR_WORD;
      addr = 32'h0000_7100; wdata = 32'hFFFF_0000;
      @(negedge clk);
      start = 1'b0; mem_write_mask = WR_NONE;
      check("busy_start_we", {31'h0, bus_we}, 32'h0);
      check("busy_start_addr", bus_addr, 32'h0000_7000);
      check("busy_start_req", {31'h0, bus_req}, 32'h1);
      bus_ack = 1'b1; bus_rdata = 32'h1111_1111;
      @(negedge clk);
      bus_ack = 1'b0;
      check("busy_start_done", {31'h0, done}, 32'h1);
      check("busy_start_rdata", rdata, 32'h1111_1111);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("busy_start_no_second", {30'h0, bus_req, busy}, 32'h0);
      end

      // reset while in REQ, then a late ack
      start_txn(RD_WORD, WR_NONE, 32'h0000_8000, 32'h0);
      check("rst_mid_req_before", {31'h0, bus_req}, 32'h1);
      #1 rst = 1'b1;
      #1 check("rst_mid_req_drop", {30'h0, bus_req, busy}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      bus_ack = 1'b1; bus_rdata = 32'h2222_2222;
      @(negedge clk);
      bus_ack = 1'b0;
      check("late_ack_done", {31'h0, done}, 32'h0);
      check("late_ack_rdata", rdata, 32'h0);
      @(negedge clk);
      check("late_ack_done2", {31'h0, done}, 32'h0);
      start_txn(RD_B_U, WR_NONE, 32'h0000_8003, 32'h0);
      check("post_rst_req", {31'h0, bus_req}, 32'h1);
      bus_ack = 1'b1; bus_rdata = 32'h7F00_0000;
      @(negedge clk);
      bus_ack = 1'b0;
      check("post_rst_done", {31'h0, done}, 32'h1);
      check("post_rst_rdata", rdata, 32'h0000_007F);
      @(negedge clk);

`ifdef LSU_TIMEOUT_EN
      start_txn(RD_NONE, WR_WORD, 32'h0000_9000, 32'h0BAD_F00D);
      for (int c = 0; c < 4; c++) begin
         check("to_req_held", {31'h0, bus_req}, 32'h1);
         check("to_no_err_yet", {31'h0, err}, 32'h0);
         @(negedge clk);
      end
      check("to_err", {31'h0, err}, 32'h1);
      check("to_req_drop", {31'h0, bus_req}, 32'h0);
      @(negedge clk);
      check("to_err_once", {31'h0, err}, 32'h0);
      start_txn(RD_NONE, WR_WORD, 32'h0000_9000, 32'h0BAD_F00D);
      repeat (3) @(negedge clk);
      check("to_ack4_req", {31'h0, bus_req}, 32'h1);
      bus_ack = 1'b1;
      @(negedge clk);
      bus_ack = 1'b0;
      check("to_ack4_done", {31'h0, done}, 32'h1);
      check("to_ack4_err", {31'h0, err}, 32'h0);
      @(negedge clk);
      check("to_ack4_err2", {31'h0, err}, 32'h0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
